// File: rtl/multdiv_sequencer.sv
// Start/handshake sequencer for the multi-cycle multiply and divide units:
// latches operands, strobes the selected unit's load, counts iterations, returns the result.
module multdiv_sequencer #(
    parameter int ITER  = 32,
    parameter int CNT_W = 6     // 2**CNT_W must exceed ITER
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] unit_operandA,
    output logic [31:0] unit_operandB,
    output logic        mult_counter_zero,
    output logic        div_counter_zero,
    input  logic [31:0] mult_result,
    input  logic        mult_exception,
    input  logic [31:0] div_result,
    input  logic        div_exception,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    typedef enum logic {OP_MULT, OP_DIV} op_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_t           state, state_nxt;
    op_t              op, op_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             start;
    logic             finish;
    logic [31:0]      sel_result;
    logic             sel_exception;

    assign start = ctrl_MULT | ctrl_DIV;

    // A start pulse pre-empts whatever is in flight, including the DONE exit edge.
    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        cnt_nxt   = '0;
        finish    = 1'b0;
        if (start) begin
            state_nxt = LOAD;
            op_nxt    = ctrl_DIV ? OP_DIV : OP_MULT;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                LOAD: state_nxt = RUN;
                RUN: begin
                    if (cnt == CNT_LAST) state_nxt = DONE;
                    else                 cnt_nxt   = cnt + 1'b1;
                end
                DONE: begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Divide-by-zero forces a zero result regardless of what the divider drives.
    always_comb begin
        sel_result    = mult_result;
        sel_exception = mult_exception;
        if (op == OP_DIV) begin
            sel_result    = div_exception ? 32'd0 : div_result;
            sel_exception = div_exception;
        end
    end

    assign busy              = (state != IDLE);
    assign mult_counter_zero = (state == LOAD) && (op == OP_MULT);
    assign div_counter_zero  = (state == LOAD) && (op == OP_DIV);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            op             <= OP_MULT;
            cnt            <= '0;
            unit_operandA  <= '0;
            unit_operandB  <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            state          <= state_nxt;
            op             <= op_nxt;
            cnt            <= cnt_nxt;
            data_resultRDY <= finish;
            if (start) begin
                unit_operandA <= data_operandA;
                unit_operandB <= data_operandB;
            end
            if (finish) begin
                data_result    <= sel_result;
                data_exception <= sel_exception;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer with behavioural unit models and a result scoreboard.
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] unit_operandA, unit_operandB;
    logic        mult_counter_zero, div_counter_zero;
    logic [31:0] mult_result, div_result;
    logic        mult_exception, div_exception;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   rdy_count = 0;
    int   start_cyc;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    multdiv_sequencer #(.ITER(32), .CNT_W(6)) dut (
        .clock(clock), .reset(reset),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .unit_operandA(unit_operandA), .unit_operandB(unit_operandB),
        .mult_counter_zero(mult_counter_zero), .div_counter_zero(div_counter_zero),
        .mult_result(mult_result), .mult_exception(mult_exception),
        .div_result(div_result), .div_exception(div_exception),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY), .busy(busy)
    );

    // Unit models: combinational from the latched operands.
    logic signed [63:0] mult_full;
    always_comb begin
        mult_full      = 64'($signed(unit_operandA)) * 64'($signed(unit_operandB));
        mult_result    = mult_full[31:0];
        mult_exception = (mult_full[63:32] != {32{mult_full[31]}});
        if (unit_operandB == 32'd0) begin
            div_result    = 32'hFFFF_FFFF;
            div_exception = 1'b1;
        end else begin
            div_result    = $signed(unit_operandA) / $signed(unit_operandB);
            div_exception = 1'b0;
        end
    end

    function automatic exp_t model(input logic d, input logic [31:0] a, b);
        exp_t e;
        logic signed [63:0] p;
        if (d) begin
            e.res = (b == 32'd0) ? 32'd0 : 32'($signed(a) / $signed(b));
            e.exc = (b == 32'd0);
        end else begin
            p     = 64'($signed(a)) * 64'($signed(b));
            e.res = p[31:0];
            e.exc = (p[63:32] != {32{p[31]}});
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every RDY pulse must match the oldest expected result.
    always @(negedge clock) begin
        if (data_resultRDY) begin
            rdy_count <= rdy_count + 1;
            check("rdy_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_result", data_result, e.res);
                check("sb_exception", 32'(data_exception), 32'(e.exc));
            end
        end
    end

    // Drive a start pulse; push an expectation if it is meant to complete.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, b,
                            input logic completes);
        @(negedge clock);
        ctrl_MULT = m; ctrl_DIV = d;
        data_operandA = a; data_operandB = b;
        if (completes) sb.push_back(model(d, a, b));
        @(negedge clock);
        start_cyc = cyc;
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = $urandom; data_operandB = $urandom;
        check("load_div_cz", 32'(div_counter_zero), 32'(d));
        check("load_mult_cz", 32'(mult_counter_zero), 32'(m & ~d));
        check("load_busy", 32'(busy), 32'd1);
        @(negedge clock);
        check("run_div_cz", 32'(div_counter_zero), 32'd0);
        check("run_mult_cz", 32'(mult_counter_zero), 32'd0);
    endtask

    task automatic wait_rdy(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (data_resultRDY) break;
            @(negedge clock);
        end
        check({tag, "_latency"}, 32'(cyc - start_cyc), 32'd34);
        check({tag, "_busy_at_rdy"}, 32'(busy), 32'd0);
        @(negedge clock);
        check({tag, "_rdy_pulse"}, 32'(data_resultRDY), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int rc0, k;
        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = 32'd0; data_operandB = 32'd0;
        repeat (3) @(negedge clock);
        check("rst_opA", unit_operandA, 32'd0);
        check("rst_result", data_result, 32'd0);
        check("rst_rdy", 32'(data_resultRDY), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // 1: divide 100/7
        start_op(1'b0, 1'b1, 32'd100, 32'd7, 1'b1);
        wait_rdy("t1");
        check("t1_result", data_result, 32'd14);

        // 2: multiply -6*7, result held while idle
        start_op(1'b1, 1'b0, -32'sd6, 32'd7, 1'b1);
        wait_rdy("t2");
        repeat (10) @(negedge clock);
        check("t2_hold", data_result, 32'hFFFF_FFD6);

        // 3: divide by zero
        start_op(1'b0, 1'b1, 32'd55, 32'd0, 1'b1);
        wait_rdy("t3");
        check("t3_result", data_result, 32'd0);
        check("t3_exc", 32'(data_exception), 32'd1);

        // 4: multiply abandoned by a divide 10 cycles later
        rc0 = rdy_count;
        start_op(1'b1, 1'b0, 32'd1000, 32'd3000, 1'b0);
        k = start_cyc;
        while (cyc < k + 9) @(negedge clock);
        start_op(1'b0, 1'b1, 32'd999, 32'd9, 1'b1);
        wait_rdy("t4");
        check("t4_rdy_count", 32'(rdy_count - rc0), 32'd1);
        check("t4_opA", unit_operandA, 32'd999);
        check("t4_opB", unit_operandB, 32'd9);
        check("t4_result", data_result, 32'd111);

        // 5: simultaneous starts, divide wins
        start_op(1'b1, 1'b1, 32'd84, 32'd4, 1'b1);
        wait_rdy("t5");
        check("t5_result", data_result, 32'd21);

        // 6: reset in the middle of a divide
        rc0 = rdy_count;
        start_op(1'b0, 1'b1, 32'd77, 32'd7, 1'b0);
        k = start_cyc;
        while (cyc < k + 20) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t6_opA", unit_operandA, 32'd0);
        check("t6_opB", unit_operandB, 32'd0);
        check("t6_result", data_result, 32'd0);
        check("t6_exc", 32'(data_exception), 32'd0);
        check("t6_rdy", 32'(data_resultRDY), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_cz", 32'({mult_counter_zero, div_counter_zero}), 32'd0);
        repeat (50) @(negedge clock);
        check("t6_no_rdy", 32'(rdy_count - rc0), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Control/handshake initiator for the multi-cycle multiply and divide datapaths.
- Accepts single-cycle ctrl_MULT / ctrl_DIV start pulses from the processor and latches the operands.
- Drives each unit's operand bus and counter_zero load strobe, and counts the iterations.
- Registers the selected unit's result and exception, then returns them with a one-cycle data_resultRDY pulse. The processor stalls on busy.

Parameters:
- ITER, 32, number of iteration cycles a unit needs after its load cycle.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > ITER.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ctrl_MULT  input  1  one-cycle start pulse for a multiply.
- ctrl_DIV  input  1  one-cycle start pulse for a divide.
- data_operandA  input  32  operand A; sampled only on a start edge.
- data_operandB  input  32  operand B; sampled only on a start edge.
- unit_operandA  output  32  latched operand A, fed to both units.
- unit_operandB  output  32  latched operand B, fed to both units.
- mult_counter_zero  output  1  load strobe for the multiplier.
- div_counter_zero  output  1  load strobe for the divider.
- mult_result  input  32  multiplier result (combinational from its register).
- mult_exception  input  1  multiplier overflow flag.
- div_result  input  32  divider result.
- div_exception  input  1  divide-by-zero flag.
- data_result  output  32  registered result; holds until the next RDY.
- data_exception  output  1  registered exception; qualified by RDY.
- data_resultRDY  output  1  one-cycle completion pulse.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, cnt=0, op=MULT.
  - unit_operandA/B=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Reset mid-operation aborts the operation; no RDY is produced for it.
- States:
  - IDLE: waiting for a start pulse.
  - LOAD: exactly one cycle. counter_zero=1 for the selected unit only, so the unit loads its operands at the LOAD exit edge.
  - RUN: cnt counts 0..ITER-1, incrementing each edge. On the edge where cnt==ITER-1, go to DONE; that is exactly ITER iteration edges.
  - DONE: exactly one cycle. At its exit edge: data_result<=selected result, data_exception<=selected exception, data_resultRDY<=1, state->IDLE.
- data_resultRDY is 0 on every other edge, so it is high for exactly one cycle.
- busy=1 in LOAD, RUN and DONE; busy=0 in IDLE.
- Start handling:
  - A start edge is any edge with ctrl_MULT|ctrl_DIV, in any state.
  - On a start edge: latch operands, set op, cnt<=0, state->LOAD.
- Latency: start edge E0 gives LOAD, RUN covers E2..E(ITER+1), DONE exit is E(ITER+2). RDY is high in the cycle after E(ITER+2), i.e. 34 edges after the start edge for ITER=32.
- Simultaneous ctrl_MULT and ctrl_DIV: DIV wins; the multiply is dropped.
- Start while busy:
  - The current operation is abandoned with no RDY, and the new operation restarts from LOAD.
  - A start on the DONE exit edge also wins: no RDY, and data_result is not updated.
- Divide exception (div_exception=1 at DONE): data_result<=0 and data_exception<=1. Otherwise the exception is passed through from the selected unit.
- Operand handling:
  - unit_operands remain stable from the start edge until the next start edge or reset.
  - data_operandA/B are ignored on non-start edges.
- Arithmetic and sign handling are owned by the units; the sequencer does no data arithmetic.
- Counter: the cnt compare is exact, never wraps, and holds 0 outside RUN.

Test Plan:
1. Reset, then ctrl_DIV with A=100, B=7 and a div model returning 14 -> div_counter_zero high for exactly 1 cycle, one cycle after start. RDY high exactly 34 edges after start; data_result=14, data_exception=0; busy low the next cycle.
2. ctrl_MULT with A=-6, B=7 and a mult model returning -42 -> only mult_counter_zero pulses. RDY at +34 with data_result=0xFFFFFFD6; data_result holds through 10 idle cycles.
3. ctrl_DIV with B=0, div_exception=1 -> RDY at +34, data_result=0, data_exception=1.
4. ctrl_MULT, then ctrl_DIV 10 cycles later -> no RDY at +34 from the first start. Exactly one RDY at 34 edges after the second start, carrying the div result; unit_operands equal the second operand pair.
5. ctrl_MULT and ctrl_DIV asserted together -> div_counter_zero pulses, mult_counter_zero stays 0, and the RDY result is the div result.
6. Reset asserted at cycle 20 of a divide -> all outputs 0 on the next cycle, busy=0, and no RDY within 50 following cycles.
